vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates VGA raster timing (default 640x480@60, 25.175 MHz pixel clock).
//  Drives x, y, active, hsync and vsync into the pattern selector and pattern generators.
//  Pattern logic counts frames on the vsync rising edge and expects x/y/active to match the syncs.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch, pixels
//  H_SYNC     96   hsync pulse width, pixels
//  H_BP       48   horizontal back porch, pixels
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch, lines
//  V_SYNC     2    vsync pulse width, lines
//  V_BP       33   vertical back porch, lines
//  SYNC_POL   0    asserted sync level (0 = active-low) for both hsync and vsync
// PORTS
//  clk          in   1   pixel clock; the only clock
//  rst          in   1   asynchronous, active-high reset
//  pix_en       in   1   pixel advance enable; counters hold when 0
//  x            out  10  horizontal position, 0..H_TOTAL-1
//  y            out  10  vertical position, 0..V_TOTAL-1
//  active       out  1   1 when x<H_ACTIVE && y<V_ACTIVE
//  hsync        out  1   horizontal sync, level per SYNC_POL
//  vsync        out  1   vertical sync, level per SYNC_POL
//  frame_start  out  1   one-cycle pulse when the raster enters (0,0)
// BEHAVIOUR
//  - H_TOTAL = sum of the four H_* parameters (800). V_TOTAL = sum of the four V_* parameters (525).
//    Both totals must be <= 1024. An elaboration check rejects larger values.
//  - Reset: x=H_TOTAL-1 (799), y=V_TOTAL-1 (524), active=0, hsync=vsync=~SYNC_POL, frame_start=0.
//    The first pix_en after reset moves the raster to (0,0) and pulses frame_start.
//  - All outputs are registered. Each is aligned in the same cycle with the x/y it describes.
//    Latency from the pix_en edge to the updated outputs is 1 clk.
//  - Horizontal phase FSM: H_ACT (x 0..639) -> H_FP (640..655) -> H_SYNC (656..751) -> H_BP (752..799) -> H_ACT.
//    The FSM leaves each state when x reaches the last pixel of that phase and pix_en=1.
//  - Vertical phase FSM: V_ACT (y 0..479) -> V_FP (480..489) -> V_SYNC (490..491) -> V_BP (492..524) -> V_ACT.
//    The vertical FSM advances only on the horizontal wrap (x=H_TOTAL-1 && pix_en).
//  - hsync is asserted iff the horizontal FSM is in H_SYNC. vsync is asserted iff the vertical FSM is in V_SYNC.
//    Both syncs change only on pixel boundaries. vsync changes only at x=0.
//  - Simultaneous wrap at (799,524): x->0 and y->0 in the same cycle, and frame_start=1.
//  - pix_en=0: all state holds and frame_start=0. frame_start never stays high for more than 1 clk.
//  - Reset asserted mid-frame returns all outputs to the reset values immediately, with no glitch pulse on the syncs.
// CONFIGURATION
//  VGA_FRAME_CNT_EN defined:
//  - Adds output frame_cnt [9:0], reset value 0.
//  - frame_cnt increments in the cycle frame_start is asserted and wraps 1023->0.
//  - This is the first-frame pulse, so frame_cnt reads 1 during frame 0.
//  VGA_FRAME_CNT_EN undefined: the frame_cnt port and its counter are absent. All other behaviour is identical.
// STRUCTURE
//  - Package vga_timing_pkg holds:
//    default timing localparams, H_TOTAL/V_TOTAL, and the 2-bit phase encoding (ACT=0, FP=1, SYNC=2, BP=3).
//  - Sub-module vga_axis_counter:
//    - Parameterised by the four phase lengths; instantiated once for the horizontal axis and once for the vertical axis.
//    - Inputs: clk, rst, adv. Outputs: pos, phase, wrap.
//    - The horizontal wrap drives the vertical adv.
// TESTING
//  1. Reset release, pix_en=1 -> cycle 1: x=0, y=0, active=1, frame_start=1. Before that: x=799, y=524, syncs=1.
//  2. 800 pix_en cycles from (0,0) -> x=0, y=1. hsync=0 for exactly 96 cycles, x=656..751.
//  3. Full frame -> vsync=0 only for y=490..491.
//     - vsync rises at (0,492), 393600 cycles after frame_start.
//     - The next frame_start comes 420000 cycles after the first.
//  4. Toggle pix_en 1/0 each clk -> raster rate halves. Outputs hold while pix_en=0. frame_start stays a 1-clk pulse.
//  5. Assert rst at (300,200) mid-line -> outputs return to the reset values at once. After release, the raster resumes from (0,0).
//  6. With VGA_FRAME_CNT_EN -> frame_cnt = 3 after the third frame_start. Without it -> the design compiles with no frame_cnt port.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60), axis phase encoding and sync-level helper.
package vga_timing_pkg;

  localparam int POS_W   = 10;
  localparam int POS_MAX = 1024;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_e;

  // Drive pol when the sync is asserted, its complement otherwise.
  function automatic logic sync_level(input logic asserted, input logic pol);
    if (asserted) begin
      return pol;
    end else begin
      return ~pol;
    end
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle between the timing generator and the pattern logic.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic             pix_en;
  logic [POS_W-1:0] x;
  logic [POS_W-1:0] y;
  logic             active;
  logic             hsync;
  logic             vsync;
  logic             frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [POS_W-1:0] frame_cnt;
`endif

  modport master (
    input  pix_en,
    output x,
    output y,
    output active,
    output hsync,
    output vsync,
    output frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output frame_cnt
`endif
  );

  modport slave (
    output pix_en,
    input  x,
    input  y,
    input  active,
    input  hsync,
    input  vsync,
    input  frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    input  frame_cnt
`endif
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACT/FP/SYNC/BP phase FSM.
// phase_o and wrap_o describe the step being taken this cycle, so the top can register aligned outputs.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACT  = DEF_H_ACTIVE,
  parameter int FP   = DEF_H_FP,
  parameter int SYNC = DEF_H_SYNC,
  parameter int BP   = DEF_H_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_i,
  output logic [POS_W-1:0] pos_o,
  output phase_e           phase_o,
  output logic             wrap_o
);

  localparam int TOTAL = ACT + FP + SYNC + BP;

  localparam logic [POS_W-1:0] END_ACT  = POS_W'(ACT - 1);
  localparam logic [POS_W-1:0] END_FP   = POS_W'(ACT + FP - 1);
  localparam logic [POS_W-1:0] END_SYNC = POS_W'(ACT + FP + SYNC - 1);
  localparam logic [POS_W-1:0] END_BP   = POS_W'(TOTAL - 1);

  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_d;
  phase_e           phase_q;
  phase_e           phase_d;
  logic             wrap_s;

  // Reset parks the axis on its last position so the first advance lands on 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q   <= END_BP;
      phase_q <= PH_BP;
    end else begin
      pos_q   <= pos_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_ACT: begin
        if (adv_i && (pos_q == END_ACT)) begin
          phase_d = PH_FP;
        end else begin
          phase_d = PH_ACT;
        end
      end
      PH_FP: begin
        if (adv_i && (pos_q == END_FP)) begin
          phase_d = PH_SYNC;
        end else begin
          phase_d = PH_FP;
        end
      end
      PH_SYNC: begin
        if (adv_i && (pos_q == END_SYNC)) begin
          phase_d = PH_BP;
        end else begin
          phase_d = PH_SYNC;
        end
      end
      PH_BP: begin
        if (adv_i && (pos_q == END_BP)) begin
          phase_d = PH_ACT;
        end else begin
          phase_d = PH_BP;
        end
      end
      default: begin
        phase_d = PH_BP;
      end
    endcase
  end

  always_comb begin
    wrap_s = adv_i && (pos_q == END_BP);
    if (!adv_i) begin
      pos_d = pos_q;
    end else if (wrap_s) begin
      pos_d = {POS_W{1'b0}};
    end else begin
      pos_d = pos_q + POS_W'(1);
    end
  end

  assign pos_o   = pos_q;
  assign phase_o = phase_d;
  assign wrap_o  = wrap_s;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered x/y/active/hsync/vsync/frame_start.
// Defining VGA_FRAME_CNT_EN adds a 10-bit wrapping frame counter on the interface.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  vga_timing_gen_if.master     vga_if
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_TOT > POS_MAX) || (V_TOT > POS_MAX)) begin : g_bad_timing
    $error("vga_timing_gen: H or V total exceeds 1024");
  end

  logic [POS_W-1:0] h_pos_s;
  logic [POS_W-1:0] v_pos_s;
  phase_e           h_phase_s;
  phase_e           v_phase_s;
  logic             h_wrap_s;
  logic             v_wrap_s;

  logic active_q;
  logic active_d;
  logic hsync_q;
  logic hsync_d;
  logic vsync_q;
  logic vsync_d;
  logic fs_q;
  logic fs_d;

  vga_axis_counter #(
    .ACT  (H_ACTIVE),
    .FP   (H_FP),
    .SYNC (H_SYNC),
    .BP   (H_BP)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .adv_i   (vga_if.pix_en),
    .pos_o   (h_pos_s),
    .phase_o (h_phase_s),
    .wrap_o  (h_wrap_s)
  );

  // The vertical axis steps once per completed line.
  vga_axis_counter #(
    .ACT  (V_ACTIVE),
    .FP   (V_FP),
    .SYNC (V_SYNC),
    .BP   (V_BP)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .adv_i   (h_wrap_s),
    .pos_o   (v_pos_s),
    .phase_o (v_phase_s),
    .wrap_o  (v_wrap_s)
  );

  always_comb begin
    active_d = (h_phase_s == PH_ACT) && (v_phase_s == PH_ACT);
    hsync_d  = sync_level(h_phase_s == PH_SYNC, SYNC_POL);
    vsync_d  = sync_level(v_phase_s == PH_SYNC, SYNC_POL);
    fs_d     = h_wrap_s && v_wrap_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      fs_q     <= 1'b0;
    end else begin
      active_q <= active_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fs_q     <= fs_d;
    end
  end

  assign vga_if.x           = h_pos_s;
  assign vga_if.y           = v_pos_s;
  assign vga_if.active      = active_q;
  assign vga_if.hsync       = hsync_q;
  assign vga_if.vsync       = vsync_q;
  assign vga_if.frame_start = fs_q;

`ifdef VGA_FRAME_CNT_EN
  logic [POS_W-1:0] frame_cnt_q;
  logic [POS_W-1:0] frame_cnt_d;

  // Counts alongside the frame_start pulse, so frame 0 already reads 1.
  always_comb begin
    if (fs_d) begin
      frame_cnt_d = frame_cnt_q + POS_W'(1);
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= {POS_W{1'b0}};
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vga_if.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a reduced-timing instance
// (32x17 raster, active-high syncs) so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int   S_HA  = 20;
  localparam int   S_HFP = 3;
  localparam int   S_HS  = 5;
  localparam int   S_HBP = 4;
  localparam int   S_VA  = 10;
  localparam int   S_VFP = 2;
  localparam int   S_VS  = 2;
  localparam int   S_VBP = 3;
  localparam logic S_POL = 1'b1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       fs;
  } obs_t;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic pix_en = 1'b0;

  int errors   = 0;
  int checks   = 0;
  int n_adv    = 0;
  bit adv_last = 1'b0;
  bit cmp_on   = 1'b0;

  vga_timing_gen_if d_if ();
  vga_timing_gen_if s_if ();

  assign d_if.pix_en = pix_en;
  assign s_if.pix_en = pix_en;

  vga_timing_gen u_dut_def (
    .clk    (clk),
    .rst    (rst),
    .vga_if (d_if)
  );

  vga_timing_gen #(
    .H_ACTIVE (S_HA),
    .H_FP     (S_HFP),
    .H_SYNC   (S_HS),
    .H_BP     (S_HBP),
    .V_ACTIVE (S_VA),
    .V_FP     (S_VFP),
    .V_SYNC   (S_VS),
    .V_BP     (S_VBP),
    .SYNC_POL (S_POL)
  ) u_dut_small (
    .clk    (clk),
    .rst    (rst),
    .vga_if (s_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // The raster is a linear walk over ht*vt positions starting one before (0,0).
  function automatic obs_t expect_at(input int ha, input int hfp, input int hs, input int hbp,
                                     input int va, input int vfp, input int vs, input int vbp,
                                     input logic pol, input int n, input bit adv);
    int   ht;
    int   vt;
    int   l;
    int   x;
    int   y;
    obs_t o;
    ht       = ha + hfp + hs + hbp;
    vt       = va + vfp + vs + vbp;
    l        = (ht * vt - 1 + n) % (ht * vt);
    x        = l % ht;
    y        = l / ht;
    o.x      = 10'(x);
    o.y      = 10'(y);
    o.active = (x < ha) && (y < va);
    o.hsync  = ((x >= ha + hfp) && (x < ha + hfp + hs)) ? pol : ~pol;
    o.vsync  = ((y >= va + vfp) && (y < va + vfp + vs)) ? pol : ~pol;
    o.fs     = adv && (l == 0);
    return o;
  endfunction

  function automatic int frames_seen(input int frame_len, input int n);
    if (n >= 1) begin
      return ((n - 1) / frame_len + 1) % 1024;
    end else begin
      return 0;
    end
  endfunction

  function automatic obs_t obs_def();
    return {d_if.x, d_if.y, d_if.active, d_if.hsync, d_if.vsync, d_if.frame_start};
  endfunction

  function automatic obs_t obs_small();
    return {s_if.x, s_if.y, s_if.active, s_if.hsync, s_if.vsync, s_if.frame_start};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_adv    <= 0;
      adv_last <= 1'b0;
    end else begin
      adv_last <= pix_en;
      if (pix_en) begin
        n_adv <= n_adv + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("def_raster", 64'(obs_def()),
            64'(expect_at(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, n_adv, adv_last)));
      check("small_raster", 64'(obs_small()),
            64'(expect_at(S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, S_POL, n_adv, adv_last)));
`ifdef VGA_FRAME_CNT_EN
      check("def_frame_cnt", 64'(d_if.frame_cnt), 64'(frames_seen(800 * 525, n_adv)));
      check("small_frame_cnt", 64'(s_if.frame_cnt), 64'(frames_seen(32 * 17, n_adv)));
`endif
    end
  end

  initial begin
    int hs_low;
    int xmin;
    int xmax;
    int cnt;
    int period;
    int vs_cnt;
    int ymin;
    int ymax;
    int rise_at;
    int rise_x;
    int rise_y;
    int fs_cnt;
    logic prev_vs;

    repeat (3) @(posedge clk);
    #1;
    cmp_on = 1'b1;
    check("def_reset", 64'(obs_def()), 64'({10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0}));
    check("small_reset", 64'(obs_small()), 64'({10'd31, 10'd16, 1'b0, 1'b0, 1'b0, 1'b0}));

    @(negedge clk);
    #2;
    rst    = 1'b0;
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    check("def_first", 64'(obs_def()), 64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1}));
    check("small_first", 64'(obs_small()), 64'({10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1}));

    hs_low = 0;
    xmin   = 1023;
    xmax   = 0;
    for (int i = 0; i < 800; i++) begin
      if (d_if.hsync == 1'b0) begin
        hs_low++;
        if (int'(d_if.x) < xmin) xmin = int'(d_if.x);
        if (int'(d_if.x) > xmax) xmax = int'(d_if.x);
      end
      @(posedge clk);
      #1;
    end
    check("def_hsync_width", 64'(hs_low), 64'(96));
    check("def_hsync_first_x", 64'(xmin), 64'(656));
    check("def_hsync_last_x", 64'(xmax), 64'(751));
    check("def_line_wrap", 64'({d_if.x, d_if.y}), 64'({10'd0, 10'd1}));

    cnt = 0;
    while ((s_if.frame_start !== 1'b1) && (cnt < 2000)) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("small_fs_found", 64'(cnt < 2000), 64'(1));

    period  = 0;
    vs_cnt  = 0;
    ymin    = 1023;
    ymax    = 0;
    rise_at = -1;
    rise_x  = -1;
    rise_y  = -1;
    prev_vs = s_if.vsync;
    do begin
      @(posedge clk);
      #1;
      period++;
      if (s_if.vsync == S_POL) begin
        vs_cnt++;
        if (int'(s_if.y) < ymin) ymin = int'(s_if.y);
        if (int'(s_if.y) > ymax) ymax = int'(s_if.y);
      end
      if ((prev_vs == S_POL) && (s_if.vsync != S_POL)) begin
        rise_at = period;
        rise_x  = int'(s_if.x);
        rise_y  = int'(s_if.y);
      end
      prev_vs = s_if.vsync;
    end while ((s_if.frame_start !== 1'b1) && (period < 2000));
    check("small_frame_period", 64'(period), 64'(544));
    check("small_vsync_cycles", 64'(vs_cnt), 64'(64));
    check("small_vsync_first_y", 64'(ymin), 64'(12));
    check("small_vsync_last_y", 64'(ymax), 64'(13));
    check("small_vsync_end_cycle", 64'(rise_at), 64'(448));
    check("small_vsync_end_pos", 64'({rise_x, rise_y}), 64'({32'sd0, 32'sd14}));

    for (int i = 0; i < 600; i++) begin
      pix_en = (i % 2 == 0);
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 3000; i++) begin
      pix_en = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("def_midreset", 64'(obs_def()), 64'({10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0}));
    check("small_midreset", 64'(obs_small()), 64'({10'd31, 10'd16, 1'b0, 1'b0, 1'b0, 1'b0}));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst    = 1'b0;
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    check("def_resume", 64'(obs_def()), 64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1}));
    check("small_resume", 64'(obs_small()), 64'({10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1}));

    fs_cnt = 1;
    cnt    = 0;
    while ((fs_cnt < 3) && (cnt < 2000)) begin
      @(posedge clk);
      #1;
      cnt++;
      if (s_if.frame_start == 1'b1) fs_cnt++;
    end
    check("small_third_fs_cycle", 64'(cnt), 64'(1088));
`ifdef VGA_FRAME_CNT_EN
    check("small_frame_cnt_3", 64'(s_if.frame_cnt), 64'(3));
    check("def_frame_cnt_1", 64'(d_if.frame_cnt), 64'(1));
`endif

    for (int i = 0; i < 1000; i++) begin
      pix_en = ($urandom_range(0, 1) != 0);
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
